// File: rtl/multi_mode_trigger_if.sv
// multi_mode_trigger_if: start/done handshake between a trigger and the HLS actor it drives
//   actor_start  : trigger -> actor, held high until the actor completes
//   actor_done   : actor -> trigger, completion strobe
//   actor_return : actor -> trigger, return code, valid while actor_done is high
interface multi_mode_trigger_if #(parameter int RET_WIDTH = 32);
  logic actor_start;
  logic actor_done;
  logic [RET_WIDTH-1:0] actor_return;
  modport master(output actor_start, input actor_done, input actor_return);
  modport slave(input actor_start, output actor_done, output actor_return);
endinterface

// File: rtl/multi_mode_trigger.sv
// multi_mode_trigger: actor trigger FSM that relaunches, backs off and joins network-wide sync
//   ap_clk, ap_rst       : clock, synchronous active-high reset
//   ap_start/ap_done     : network start request / one-cycle completion pulse
//   ap_idle              : high while IDLE
//   actor                : master side of the actor start/done/return handshake
//   external_enqueue     : boundary FIFO activity, wakes SLEEP early when MODE != 0
//   all_sleep/all_sync/any_sync_exec : network-wide trigger status
//   sleep/sync_wait/sync_exec        : this trigger's status for the network
//   fire_count           : EXECUTED count since start, only when TRIGGER_STATS_EN is defined
module multi_mode_trigger #(
  parameter int MODE = 0,
  parameter int RET_WIDTH = 32,
  parameter int SLEEP_CYCLES = 4,
  parameter int SLEEP_WIDTH = 8
) (
  input  logic ap_clk,
  input  logic ap_rst,
  input  logic ap_start,
  output logic ap_done,
  output logic ap_idle,
  multi_mode_trigger_if.master actor,
  input  logic external_enqueue,
  input  logic all_sleep,
  input  logic all_sync,
  input  logic any_sync_exec,
  output logic sleep,
  output logic sync_wait,
  output logic sync_exec
`ifdef TRIGGER_STATS_EN
  , output logic [31:0] fire_count
`endif
);
  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_CHECK, S_SLEEP, S_SYNC_LAUNCH, S_SYNC_CHECK, S_SYNC_WAIT, S_SYNC_EXEC
  } state_t;
  localparam logic [RET_WIDTH-1:0] EXECUTED = RET_WIDTH'(5);
  state_t state, state_nxt;
  logic [RET_WIDTH-1:0] ret;
  logic [SLEEP_WIDTH-1:0] cnt;
  logic exec;
  assign exec = ret == EXECUTED;
  always_ff @(posedge ap_clk)
    if (ap_rst) state <= S_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:        state_nxt = ap_start ? S_LAUNCH : S_IDLE;
      S_LAUNCH:      state_nxt = actor.actor_done ? S_CHECK : S_LAUNCH;
      S_SYNC_LAUNCH: state_nxt = actor.actor_done ? S_SYNC_CHECK : S_SYNC_LAUNCH;
      S_CHECK:       state_nxt = exec ? S_LAUNCH : S_SLEEP;
      // boundary FIFO wake-up beats the network sync, which beats the back-off timeout
      S_SLEEP:       state_nxt = (MODE != 0 && external_enqueue) ? S_LAUNCH :
                                 all_sleep ? S_SYNC_LAUNCH :
                                 cnt == SLEEP_WIDTH'(1) ? S_LAUNCH : S_SLEEP;
      S_SYNC_CHECK:  state_nxt = exec ? S_SYNC_EXEC : S_SYNC_WAIT;
      S_SYNC_EXEC:   state_nxt = all_sync ? S_LAUNCH : S_SYNC_EXEC;
      S_SYNC_WAIT:   state_nxt = all_sync ? (any_sync_exec ? S_LAUNCH : S_IDLE) : S_SYNC_WAIT;
      default:       state_nxt = S_IDLE;
    endcase
  end
  // ap_done is registered so it carries no combinational path from all_sync; it
  // pulses in the first IDLE cycle after the SYNC_WAIT exit
  always_ff @(posedge ap_clk)
    if (ap_rst) begin
      ret <= '0;
      cnt <= '0;
      ap_done <= 1'b0;
    end else begin
      if ((state == S_LAUNCH || state == S_SYNC_LAUNCH) && actor.actor_done) ret <= actor.actor_return;
      if (state == S_CHECK && !exec) cnt <= SLEEP_WIDTH'(SLEEP_CYCLES);
      else if (state == S_SLEEP && cnt != '0) cnt <= cnt - 1'b1;
      ap_done <= state == S_SYNC_WAIT && all_sync && !any_sync_exec;
    end
  always_comb begin
    ap_idle = state == S_IDLE;
    actor.actor_start = state == S_LAUNCH || state == S_SYNC_LAUNCH;
    sleep = state == S_SLEEP;
    sync_wait = state == S_SYNC_WAIT;
    sync_exec = state == S_SYNC_EXEC;
  end
`ifdef TRIGGER_STATS_EN
  always_ff @(posedge ap_clk)
    if (ap_rst || (state == S_IDLE && ap_start)) fire_count <= '0;
    else if ((state == S_CHECK || state == S_SYNC_CHECK) && exec && fire_count != '1)
      fire_count <= fire_count + 1'b1;
`endif
endmodule

// File: tb/tb_multi_mode_trigger.sv
// tb_multi_mode_trigger: randomized scoreboard bench running a MODE=0 and a MODE=1 trigger side by side
module tb_multi_mode_trigger;
  localparam int SC = 4;
  localparam int RW = 32;
  typedef enum int {EV_START, EV_SLEEP, EV_SWAIT, EV_SEXEC, EV_DONE} ev_kind_t;
  typedef struct {ev_kind_t kind; int val;} ev_t;
  typedef struct {int len; logic [RW-1:0] code;} launch_t;
  typedef struct {int k; bit ext; bit as;} sleep_t;
  typedef struct {int d; bit any;} sync_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    logic rst = 1'b1;
    logic ap_start = 1'b0, ext = 1'b0, all_sleep = 1'b0, all_sync = 1'b0, any_exec = 1'b0;
    logic ap_done, ap_idle, sleep, sync_wait, sync_exec;
`ifdef TRIGGER_STATS_EN
    logic [31:0] fire_count;
`endif
    bit go = 1'b0;
    bit mon_en = 1'b1;
    bit fin = 1'b0;
    int model_fires = 0;
    ev_t exp_q[$];
    launch_t lq[$];
    sleep_t sq[$];
    sync_t yq[$];

    multi_mode_trigger_if #(.RET_WIDTH(RW)) act_if ();
    multi_mode_trigger #(.MODE(g), .RET_WIDTH(RW), .SLEEP_CYCLES(SC), .SLEEP_WIDTH(8)) dut (
      .ap_clk(clk), .ap_rst(rst), .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle),
      .actor(act_if), .external_enqueue(ext), .all_sleep(all_sleep), .all_sync(all_sync),
      .any_sync_exec(any_exec), .sleep(sleep), .sync_wait(sync_wait), .sync_exec(sync_exec)
`ifdef TRIGGER_STATS_EN
      , .fire_count(fire_count)
`endif
    );

    // expected-event model: each planned phase maps to the event it must produce
    task automatic plan_launch(input int len, input logic [RW-1:0] code);
      lq.push_back('{len: len, code: code});
      exp_q.push_back('{kind: EV_START, val: len});
      if (code == RW'(5)) model_fires++;
    endtask

    task automatic plan_sleep(input int k, input bit e, input bit a, output bit to_sync);
      sq.push_back('{k: k, ext: e, as: a});
      if (e && g != 0) begin
        exp_q.push_back('{kind: EV_SLEEP, val: k});
        to_sync = 1'b0;
      end else if (a) begin
        exp_q.push_back('{kind: EV_SLEEP, val: k});
        to_sync = 1'b1;
      end else begin
        exp_q.push_back('{kind: EV_SLEEP, val: SC});
        to_sync = 1'b0;
      end
    endtask

    task automatic plan_sync(input int d, input bit any, input bit executed);
      yq.push_back('{d: d, any: any});
      exp_q.push_back('{kind: executed ? EV_SEXEC : EV_SWAIT, val: d});
      if (!executed && !any) exp_q.push_back('{kind: EV_DONE, val: 1});
    endtask

    task automatic gen_random;
      bit sync_ctx, over, ts, any;
      int steps, r;
      logic [1:0] t;
      logic [RW-1:0] code;
      sync_ctx = 1'b0;
      over = 1'b0;
      steps = 0;
      model_fires = 0;
      while (!over) begin
        r = int'($urandom_range(0, 9));
        code = r < 5 ? RW'(5) : r == 9 ? RW'(32'hDEAD_0005) : RW'(r - 5);
        steps++;
        if (steps > 10) code = RW'(2);
        plan_launch(int'($urandom_range(1, 3)), code);
        if (sync_ctx) begin
          any = steps > 10 ? 1'b0 : 1'($urandom);
          plan_sync(int'($urandom_range(1, 3)), any, code == RW'(5));
          over = code != RW'(5) && !any;
          sync_ctx = 1'b0;
        end else if (code != RW'(5)) begin
          t = 2'($urandom_range(0, 3));
          if (steps > 10) t = 2'b10;
          plan_sleep(int'($urandom_range(1, SC)), t[0], t[1], ts);
          sync_ctx = ts;
        end
      end
    endtask

    task automatic run_episode(input string tag);
      tick;
      go = 1'b1;
      tick;
      go = 1'b0;
`ifdef TRIGGER_STATS_EN
      check($sformatf("m%0d_%s_fire_clear", g, tag), fire_count, 0);
`endif
      for (int i = 0; i < 1000 && (exp_q.size() != 0 || !ap_idle); i++) tick;
      check($sformatf("m%0d_%s_pending_events", g, tag), exp_q.size(), 0);
      check($sformatf("m%0d_%s_idle", g, tag), ap_idle, 1);
`ifdef TRIGGER_STATS_EN
      check($sformatf("m%0d_%s_fire_count", g, tag), fire_count, model_fires);
`endif
      if (exp_q.size() != 0 || !ap_idle) begin
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        exp_q.delete();
        lq.delete();
        sq.delete();
        yq.delete();
      end
    endtask

    // responder: plays actor and network, consuming one plan entry per phase entry
    int la_c = 0, sl_c = 0, sy_c = 0;
    launch_t cl;
    sleep_t cs;
    sync_t cy;
    always @(negedge clk) begin
      if (rst) begin
        la_c = 0;
        sl_c = 0;
        sy_c = 0;
        ap_start = 1'b0;
        act_if.actor_done = 1'b0;
        act_if.actor_return = '0;
        ext = 1'b0;
        all_sleep = 1'b0;
        all_sync = 1'b0;
        any_exec = 1'b0;
      end else begin
        ap_start = ap_idle ? go : 1'($urandom);
        if (act_if.actor_start) begin
          if (la_c == 0) begin
            if (lq.size() != 0) cl = lq.pop_front();
            else cl = '{len: 1, code: '0};
          end
          la_c++;
          act_if.actor_done = la_c == cl.len;
          act_if.actor_return = la_c == cl.len ? cl.code : RW'($urandom);
        end else begin
          la_c = 0;
          act_if.actor_done = 1'($urandom);
          act_if.actor_return = RW'($urandom);
        end
        if (sleep) begin
          if (sl_c == 0) begin
            if (sq.size() != 0) cs = sq.pop_front();
            else cs = '{k: SC + 1, ext: 1'b0, as: 1'b0};
          end
          sl_c++;
          ext = cs.ext && sl_c >= cs.k;
          all_sleep = cs.as && sl_c >= cs.k;
        end else begin
          sl_c = 0;
          ext = 1'($urandom);
          all_sleep = 1'($urandom);
        end
        if (sync_wait || sync_exec) begin
          if (sy_c == 0) begin
            if (yq.size() != 0) cy = yq.pop_front();
            else cy = '{d: 1, any: 1'b0};
          end
          sy_c++;
          all_sync = sy_c >= cy.d;
          any_exec = cy.any;
        end else begin
          sy_c = 0;
          all_sync = 1'($urandom);
          any_exec = 1'($urandom);
        end
      end
    end

    // monitor: turns output runs into events and checks them against the queue
    int r_st = 0, r_sl = 0, r_sw = 0, r_se = 0, r_dn = 0;
    task automatic emit(input ev_kind_t k, input int v);
      ev_t e;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL m%0d_unexpected_event: got %s len %0d, want none", g, k.name(), v);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("m%0d_event_kind(got %s want %s)", g, k.name(), e.kind.name()), k, e.kind);
        check($sformatf("m%0d_%s_length", g, e.kind.name()), v, e.val);
      end
    endtask

    always @(negedge clk) begin
      if (rst || !mon_en) begin
        r_st = 0;
        r_sl = 0;
        r_sw = 0;
        r_se = 0;
        r_dn = 0;
      end else begin
        if (act_if.actor_start) r_st++;
        else if (r_st != 0) begin emit(EV_START, r_st); r_st = 0; end
        if (sleep) r_sl++;
        else if (r_sl != 0) begin emit(EV_SLEEP, r_sl); r_sl = 0; end
        if (sync_wait) r_sw++;
        else if (r_sw != 0) begin emit(EV_SWAIT, r_sw); r_sw = 0; end
        if (sync_exec) r_se++;
        else if (r_se != 0) begin emit(EV_SEXEC, r_se); r_se = 0; end
        if (ap_done) r_dn++;
        else if (r_dn != 0) begin emit(EV_DONE, r_dn); r_dn = 0; end
      end
    end

    initial begin : drv
      bit ts;
      repeat (3) tick;
      check($sformatf("m%0d_reset_outputs", g),
            {act_if.actor_start, ap_done, sleep, sync_wait, sync_exec, ap_idle}, 6'b000001);
`ifdef TRIGGER_STATS_EN
      check($sformatf("m%0d_reset_fire_count", g), fire_count, 0);
`endif
      rst = 1'b0;
      model_fires = 0;
      plan_launch(1, RW'(5));
      plan_launch(2, RW'(5));
      plan_launch(3, RW'(5));
      plan_launch(2, RW'(2));
      plan_sleep(1, 1'b0, 1'b0, ts);
      plan_launch(1, RW'(1));
      plan_sleep(2, 1'b0, 1'b1, ts);
      plan_launch(1, RW'(2));
      plan_sync(2, 1'b0, 1'b0);
      run_episode("directed");
      model_fires = 0;
      plan_launch(1, RW'(3));
      plan_sleep(2, 1'b1, 1'b1, ts);
      if (ts) begin
        plan_launch(2, RW'(2));
        plan_sync(1, 1'b0, 1'b0);
      end else begin
        plan_launch(2, RW'(0));
        plan_sleep(1, 1'b0, 1'b1, ts);
        plan_launch(1, RW'(4));
        plan_sync(1, 1'b0, 1'b0);
      end
      run_episode("wake_priority");
      repeat (25) begin
        gen_random;
        run_episode("rand");
      end
      mon_en = 1'b0;
      lq.push_back('{len: 50, code: RW'(5)});
      tick;
      go = 1'b1;
      tick;
      go = 1'b0;
      tick;
      tick;
      check($sformatf("m%0d_launch_before_reset", g), act_if.actor_start, 1);
      rst = 1'b1;
      tick;
      check($sformatf("m%0d_reset_mid_launch", g), {act_if.actor_start, ap_idle}, 2'b01);
`ifdef TRIGGER_STATS_EN
      check($sformatf("m%0d_reset_mid_launch_fire", g), fire_count, 0);
`endif
      rst = 1'b0;
      lq.delete();
      mon_en = 1'b1;
      gen_random;
      run_episode("after_reset");
      fin = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 80000 && !(u[0].fin && u[1].fin); i++) @(posedge clk);
    check("both_benches_finished", u[0].fin && u[1].fin, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_mode_trigger.md
MULTI_MODE_TRIGGER -- requirements
Module: multi_mode_trigger

Interface
REQ-001 SHALL have parameter MODE, default 0: 0=actor trigger, 1=input trigger, 2=output trigger.
REQ-002 SHALL have parameter RET_WIDTH, default 32: width of the actor return code.
REQ-003 SHALL have parameter SLEEP_CYCLES, default 4, legal range 1..2^SLEEP_WIDTH-1: retry back-off length.
REQ-004 SHALL have parameter SLEEP_WIDTH, default 8: width of the sleep counter.
REQ-005 SHALL have port ap_clk, in, 1: the single clock.
REQ-006 SHALL have port ap_rst, in, 1: reset, synchronous, active-high.
REQ-007 SHALL have port ap_start, in, 1: network start request.
REQ-008 SHALL have port ap_done, out, 1: one-cycle completion pulse.
REQ-009 SHALL have port ap_idle, out, 1: high when state is IDLE.
REQ-010 SHALL have port actor_start, out, 1: HLS ap_start to the actor.
REQ-011 SHALL have port actor_done, in, 1: HLS ap_done from the actor.
REQ-012 SHALL have port actor_return, in, RET_WIDTH: actor return code, valid with actor_done.
REQ-013 SHALL have port external_enqueue, in, 1: data arrived or space freed on the boundary FIFO; ignored when MODE=0.
REQ-014 SHALL have port all_sleep, in, 1: every trigger in the network is in SLEEP.
REQ-015 SHALL have port all_sync, in, 1: every trigger is in SYNC_WAIT or SYNC_EXEC.
REQ-016 SHALL have port any_sync_exec, in, 1: at least one trigger is in SYNC_EXEC.
REQ-017 SHALL have ports sleep, sync_wait and sync_exec, out, 1 each: high in SLEEP, SYNC_WAIT and SYNC_EXEC respectively.

Function
REQ-018 SHALL use states IDLE, LAUNCH, CHECK, SLEEP, SYNC_LAUNCH, SYNC_CHECK, SYNC_WAIT, SYNC_EXEC, held in a 3-bit register.
REQ-019 SHALL encode return codes as IDLE=0, WAIT_PREDICATE=1, WAIT_INPUT=2, WAIT_OUTPUT=3, WAIT_GUARD=4, EXECUTED=5; any other value SHALL be treated as a non-EXECUTED code.
REQ-020 IDLE: on ap_start=1, SHALL go to LAUNCH next cycle; ap_start in any other state SHALL be ignored.
REQ-021 LAUNCH / SYNC_LAUNCH: SHALL hold actor_start=1 until actor_done=1, then capture actor_return and go to CHECK / SYNC_CHECK respectively.
REQ-022 actor_done SHALL be sampled only in LAUNCH and SYNC_LAUNCH; in other states it SHALL be ignored.
REQ-023 CHECK: EXECUTED SHALL go to LAUNCH; any other code SHALL load the counter with SLEEP_CYCLES and go to SLEEP.
REQ-024 SLEEP: the counter SHALL decrement by 1 each cycle, without wrapping below 0.
REQ-025 SLEEP exit priority:
  - (1) MODE!=0 and external_enqueue=1 -> LAUNCH;
  - (2) all_sleep=1 -> SYNC_LAUNCH;
  - (3) counter==1 -> LAUNCH.
REQ-026 SYNC_CHECK: EXECUTED SHALL go to SYNC_EXEC; any other code SHALL go to SYNC_WAIT.
REQ-027 SYNC_EXEC: on all_sync=1 SHALL go to LAUNCH.
REQ-028 SYNC_WAIT: on all_sync=1, SHALL go to LAUNCH if any_sync_exec=1, otherwise to IDLE.
REQ-029 On the SYNC_WAIT->IDLE transition, ap_done SHALL be 1 for exactly that one cycle.
REQ-030 All outputs SHALL be registered or decoded from the state register only; there SHALL be no combinational path from any input to any output.

Reset
REQ-031 ap_rst=1 at a clock edge SHALL force state=IDLE, counter=0 and the captured return=0, including mid-LAUNCH; an actor handshake in progress SHALL be abandoned.
REQ-032 During and after reset: actor_start=0, ap_done=0, sleep=0, sync_wait=0, sync_exec=0, ap_idle=1.

Configuration
REQ-033 With macro TRIGGER_STATS_EN defined, the module SHALL add output fire_count, 32 bits.
  - Increments on each EXECUTED seen in CHECK or SYNC_CHECK.
  - Saturates at 0xFFFFFFFF.
  - Clears on reset and when ap_start is accepted in IDLE.
REQ-034 Without TRIGGER_STATS_EN, fire_count and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-035 Reset, then ap_start pulse; actor returns EXECUTED 3 times then WAIT_INPUT -> actor_start high 4 times, then sleep=1.
REQ-036 MODE=0, SLEEP_CYCLES=4, all_sleep=0 in SLEEP -> sleep=1 for exactly 4 cycles, then actor_start=1.
REQ-037 In SLEEP, all_sleep=1 -> SYNC_LAUNCH; actor returns WAIT_INPUT; all_sync=1, any_sync_exec=0 -> ap_done=1 for 1 cycle, then ap_idle=1.
REQ-038 MODE=1, in SLEEP with external_enqueue=1 and all_sleep=1 in the same cycle -> LAUNCH, not SYNC_LAUNCH; MODE=0 with the same stimulus -> SYNC_LAUNCH.
REQ-039 ap_rst=1 while actor_start=1 -> next cycle actor_start=0, ap_idle=1; with TRIGGER_STATS_EN, fire_count=0.
REQ-040 TRIGGER_STATS_EN defined, 7 EXECUTED returns -> fire_count=7; a new ap_start -> fire_count=0.
